// File: rtl/mb_lane_mapper_stream_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mb_mapper_pkg
// Purpose  : Mode encodings, FSM state type and beat/mask helpers for the
//            mainband lane mapper.
// Revision : 1.0 - initial release
// ============================================================================
package mb_mapper_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_X8_LO = 2'b01;
    localparam logic [1:0] MODE_X8_HI = 2'b10;
    localparam logic [1:0] MODE_X16   = 2'b11;

    localparam int MAX_LANES = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int active_lanes(input logic [1:0] mode, input int num_lanes);
        return (mode == MODE_X16) ? num_lanes : num_lanes / 2;
    endfunction

    function automatic int beats(input logic [1:0] mode, input int n_bytes,
                                 input int lane_w, input int num_lanes);
        return n_bytes / ((lane_w / 8) * active_lanes(mode, num_lanes));
    endfunction

    function automatic logic [MAX_LANES-1:0] lane_mask(input logic [1:0] mode,
                                                       input int num_lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int j = 0; j < num_lanes; j++) begin
            case (mode)
                MODE_X16:   m[j] = 1'b1;
                MODE_X8_LO: m[j] = (j < num_lanes / 2);
                MODE_X8_HI: m[j] = (j >= num_lanes / 2);
                default:    m[j] = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mb_lane_mapper_stream_if.sv
`default_nettype none
// ============================================================================
// Interface : mb_lane_mapper_stream_if
// Purpose   : Flit input handshake and lane-beat output bundle of the mapper.
// Revision  : 1.0 - initial release
// ============================================================================
interface mb_lane_mapper_stream_if #(
    parameter int LANE_W    = 32,
    parameter int N_BYTES   = 1024,
    parameter int NUM_LANES = 16
);
    logic                          i_valid;
    logic                          o_ready;
    logic [8*N_BYTES-1:0]          i_data;
    logic [1:0]                    i_mode;
    logic [NUM_LANES*LANE_W-1:0]   o_lanes;
    logic                          o_lane_valid;
    logic [NUM_LANES-1:0]          o_lane_en;
    logic                          o_busy;
    logic                          o_done;

    modport slave (
        input  i_valid, i_data, i_mode,
        output o_ready, o_lanes, o_lane_valid, o_lane_en, o_busy, o_done
    );

    modport master (
        output i_valid, i_data, i_mode,
        input  o_ready, o_lanes, o_lane_valid, o_lane_en, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/mb_lane_mapper_stream_slice_mux.sv
`default_nettype none
// ============================================================================
// Module   : mb_lane_slice_mux
// Purpose  : Places the active lane slices of the current beat onto the
//            physical lanes by mode, with optional in-group lane reversal.
// Revision : 1.0 - initial release
// ============================================================================
module mb_lane_slice_mux
    import mb_mapper_pkg::*;
#(
    parameter int LANE_W    = 32,
    parameter int NUM_LANES = 16
) (
    input  wire logic [1:0]                  i_mode,
    input  wire logic                        i_rev,
    input  wire logic [NUM_LANES*LANE_W-1:0] i_data,
    output logic      [NUM_LANES*LANE_W-1:0] o_lanes
);
    localparam int HALF = NUM_LANES / 2;

    for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
        // Position of physical lane j inside its half-width group
        localparam int  POS      = (j < HALF) ? j : j - HALF;
        localparam int  POS_REV  = HALF - 1 - POS;
        localparam int  FULL_REV = NUM_LANES - 1 - j;
        localparam bit  IN_LO    = (j < HALF);

        logic [LANE_W-1:0] w_lane;

        always_comb begin
            w_lane = '0;
            case (i_mode)
                MODE_X16:
                    w_lane = i_rev ? i_data[FULL_REV*LANE_W +: LANE_W]
                                   : i_data[j*LANE_W +: LANE_W];
                MODE_X8_LO:
                    if (IN_LO) begin
                        w_lane = i_rev ? i_data[POS_REV*LANE_W +: LANE_W]
                                       : i_data[POS*LANE_W +: LANE_W];
                    end
                MODE_X8_HI:
                    if (!IN_LO) begin
                        w_lane = i_rev ? i_data[POS_REV*LANE_W +: LANE_W]
                                       : i_data[POS*LANE_W +: LANE_W];
                    end
                default: w_lane = '0;
            endcase
        end

        assign o_lanes[j*LANE_W +: LANE_W] = w_lane;
    end
endmodule
`default_nettype wire

// File: rtl/mb_lane_mapper_stream.sv
`default_nettype none
// ============================================================================
// Module   : mb_lane_mapper_stream
// Purpose  : Streams one flit per handshake across x16 / x8-lo / x8-hi lanes,
//            one beat per cycle. MB_LANE_REVERSAL_EN adds i_lane_rev.
// Revision : 1.0 - initial release
// ============================================================================
module mb_lane_mapper_stream
    import mb_mapper_pkg::*;
#(
    parameter int LANE_W    = 32,
    parameter int N_BYTES   = 1024,
    parameter int NUM_LANES = 16
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst_n,
`ifdef MB_LANE_REVERSAL_EN
    input  wire logic                 i_lane_rev,
`endif
    mb_lane_mapper_stream_if.slave    bus
);
    localparam int DATA_W    = 8 * N_BYTES;
    localparam int LANES_W   = NUM_LANES * LANE_W;
    localparam int HALF_W    = LANES_W / 2;
    localparam int BEATS_X16 = beats(MODE_X16, N_BYTES, LANE_W, NUM_LANES);
    localparam int BEATS_X8  = beats(MODE_X8_LO, N_BYTES, LANE_W, NUM_LANES);
    localparam int CNT_W     = $clog2(BEATS_X8 + 1);
    localparam logic [CNT_W-1:0] LAST_X16 = CNT_W'(BEATS_X16 - 1);
    localparam logic [CNT_W-1:0] LAST_X8  = CNT_W'(BEATS_X8 - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [1:0]          mode_q,  mode_d;
    logic                rev_q,   rev_d;

    logic                w_rev_in;
    logic                w_last;
    logic                w_ready;
    logic                w_accept;
    logic                w_send;
    logic [LANES_W-1:0]  w_mux;
    logic [NUM_LANES-1:0] w_mask;

`ifdef MB_LANE_REVERSAL_EN
    assign w_rev_in = i_lane_rev;
`else
    assign w_rev_in = 1'b0;
`endif

    assign w_send   = (state_q == ST_SEND);
    assign w_last   = w_send && (cnt_q == ((mode_q == MODE_X16) ? LAST_X16 : LAST_X8));
    assign w_ready  = (bus.i_mode != MODE_OFF) && ((state_q == ST_IDLE) || w_last);
    assign w_accept = bus.i_valid && w_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= MODE_OFF;
            rev_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            rev_q   <= rev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        rev_d   = rev_q;
        if (w_accept) begin
            // An accept on the last beat chains straight into the next flit
            state_d = ST_SEND;
            cnt_d   = '0;
            data_d  = bus.i_data;
            mode_d  = bus.i_mode;
            rev_d   = w_rev_in;
        end else if (w_send) begin
            if (w_last) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                data_d  = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                data_d = (mode_q == MODE_X16) ? (data_q >> LANES_W) : (data_q >> HALF_W);
            end
        end
    end

    mb_lane_slice_mux #(
        .LANE_W    (LANE_W),
        .NUM_LANES (NUM_LANES)
    ) u_slice_mux (
        .i_mode  (mode_q),
        .i_rev   (rev_q),
        .i_data  (data_q[LANES_W-1:0]),
        .o_lanes (w_mux)
    );

    assign w_mask           = NUM_LANES'(lane_mask(mode_q, NUM_LANES));
    assign bus.o_ready      = w_ready;
    assign bus.o_lanes      = w_send ? w_mux : '0;
    assign bus.o_lane_valid = w_send;
    assign bus.o_lane_en    = w_send ? w_mask : '0;
    assign bus.o_busy       = w_send;
    assign bus.o_done       = w_last;
endmodule
`default_nettype wire

// File: tb/tb_mb_lane_mapper_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_lane_mapper_stream
// Purpose  : Scoreboard bench for the streaming lane mapper; expected beats
//            are built from a byte-level model of the lane placement rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mb_lane_mapper_stream;
    localparam int LANE_W    = 32;
    localparam int N_BYTES   = 1024;
    localparam int NUM_LANES = 16;
    localparam int CHUNK     = LANE_W / 8;
    localparam int LW        = NUM_LANES * LANE_W;
    localparam int DW        = 8 * N_BYTES;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

`ifdef MB_LANE_REVERSAL_EN
    logic lane_rev = 1'b0;
`endif

    mb_lane_mapper_stream_if #(
        .LANE_W(LANE_W), .N_BYTES(N_BYTES), .NUM_LANES(NUM_LANES)
    ) bus ();

    mb_lane_mapper_stream #(
        .LANE_W(LANE_W), .N_BYTES(N_BYTES), .NUM_LANES(NUM_LANES)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
`ifdef MB_LANE_REVERSAL_EN
        .i_lane_rev (lane_rev),
`endif
        .bus        (bus)
    );

    typedef struct {
        logic [LW-1:0]        lanes;
        logic [NUM_LANES-1:0] en;
        logic                 done;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: beat k, logical lane l of the A-lane group carries bytes
    // (k*A + src)*CHUNK.. where src is l or its mirror within the group.
    function automatic void push_flit(input logic [DW-1:0] d, input logic [1:0] mode, input bit rev);
        int a    = (mode == 2'b11) ? NUM_LANES : NUM_LANES / 2;
        int base = (mode == 2'b10) ? NUM_LANES / 2 : 0;
        int nb   = N_BYTES / (CHUNK * a);
        for (int k = 0; k < nb; k++) begin
            beat_t b;
            b.lanes = '0;
            b.en    = '0;
            b.done  = (k == nb - 1);
            for (int l = 0; l < a; l++) begin
                int src = rev ? a - 1 - l : l;
                b.en[base + l] = 1'b1;
                for (int c = 0; c < CHUNK; c++)
                    b.lanes[(base + l) * LANE_W + 8 * c +: 8] = d[8 * ((k * a + src) * CHUNK + c) +: 8];
            end
            exp_q.push_back(b);
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: compares every presented beat against the scoreboard head
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (bus.o_lane_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got valid beat expected none at %0t", $time);
                end else begin
                    b = exp_q.pop_front();
                    check("lanes",   bus.o_lanes,   b.lanes);
                    check("lane_en", bus.o_lane_en, LW'(b.en));
                    check("done",    bus.o_done,    LW'(b.done));
                    check("busy",    bus.o_busy,    LW'(1'b1));
                end
            end else begin
                check("idle_lanes", bus.o_lanes, '0);
                check("idle_ctrl", LW'({bus.o_done, bus.o_lane_en, bus.o_busy}), '0);
                check("beat_missing", LW'(exp_q.size() != 0), '0);
            end
        end
    end

    task automatic cycle(input bit v, input logic [1:0] m, input logic [DW-1:0] d, input bit rev);
        bit exp_rdy;
        bit rev_eff;
        @(negedge clk);
        #2;
        bus.i_valid = v;
        bus.i_mode  = m;
        bus.i_data  = d;
`ifdef MB_LANE_REVERSAL_EN
        lane_rev = rev;
        rev_eff  = rev;
`else
        rev_eff  = 1'b0;
`endif
        #1;
        exp_rdy = (m != 2'b00) && (exp_q.size() == 0) && rst_n;
        check("ready", LW'(bus.o_ready), LW'(exp_rdy));
        if (v && exp_rdy) push_flit(d, m, rev_eff);
    endtask

    logic [DW-1:0] ramp;
    logic [DW-1:0] rd;

    initial begin
        bus.i_valid = 1'b0;
        bus.i_mode  = 2'b00;
        bus.i_data  = '0;
        for (int b = 0; b < N_BYTES; b++) ramp[8 * b +: 8] = 8'(b);

        #1 rst_n = 1'b0;
        #1;
        check("reset_state", LW'({bus.o_lane_valid, bus.o_lane_en, bus.o_busy, bus.o_done}), '0);
        check("reset_lanes", bus.o_lanes, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        // Single flits in each mode, followed by idle time
        cycle(1'b1, 2'b11, ramp, 1'b0);
        repeat (20) cycle(1'b0, 2'b11, ramp, 1'b0);
        cycle(1'b1, 2'b01, ramp, 1'b0);
        repeat (34) cycle(1'b0, 2'b01, ramp, 1'b0);
        cycle(1'b1, 2'b10, ramp, 1'b0);
        repeat (34) cycle(1'b0, 2'b10, ramp, 1'b0);

        // Back-to-back: valid held until the second flit is accepted
        repeat (17) cycle(1'b1, 2'b11, ramp, 1'b0);
        repeat (20) cycle(1'b0, 2'b11, ramp, 1'b0);

`ifdef MB_LANE_REVERSAL_EN
        cycle(1'b1, 2'b11, ramp, 1'b1);
        repeat (20) cycle(1'b0, 2'b11, ramp, 1'b0);
        cycle(1'b1, 2'b10, ramp, 1'b1);
        repeat (34) cycle(1'b0, 2'b10, ramp, 1'b0);
`endif

        // Reset in the middle of a flit, then mode 00 with valid asserted
        rd = rand_data();
        cycle(1'b1, 2'b11, rd, 1'b0);
        repeat (5) cycle(1'b0, 2'b11, rd, 1'b0);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_mid_flit", LW'({bus.o_lane_valid, bus.o_lane_en, bus.o_busy, bus.o_done}), '0);
        check("reset_mid_lanes", bus.o_lanes, '0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (10) cycle(1'b1, 2'b00, rand_data(), 1'b0);

        // Randomised traffic: mode, valid, data and reversal all vary
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 3) != 0, 2'($urandom % 4), rand_data(), 1'($urandom % 2));
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(1'b0, 2'b00, '0, 1'b0);
        check("drain", LW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
